// File: rtl/comparator_nbit_serial.sv
// rtl/comparator_nbit_serial.sv - bit-serial MSB-first unsigned magnitude comparator
module comparator_nbit_serial #(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_maior_que_b,
    output logic             a_menor_que_b,
    output logic             a_igual_b,
    output logic [IDXW-1:0]  diff_idx
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COMPARE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [IDXW-1:0]   cnt;
    logic              gt_f;
    logic              lt_f;
    logic [IDXW-1:0]   idx_f;

    logic              load;
    logic              step;
    logic              finish;

    // 1-bit compare slice: the current MSB pair only decides while no earlier bit has
    logic              a_bit;
    logic              b_bit;
    logic              decide_now;
    logic              gt_nxt;
    logic              lt_nxt;
    logic [IDXW-1:0]   idx_nxt;

    assign a_bit      = a_sh[WIDTH-1];
    assign b_bit      = b_sh[WIDTH-1];
    assign decide_now = ~gt_f & ~lt_f & (a_bit ^ b_bit);
    assign gt_nxt     = decide_now ? a_bit : gt_f;
    assign lt_nxt     = decide_now ? b_bit : lt_f;
    assign idx_nxt    = decide_now ? cnt   : idx_f;

    assign busy = (state == S_COMPARE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control: accept start only in IDLE, stop after bit 0
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_COMPARE;
                end
            end
            S_COMPARE: begin
                step = 1'b1;
                if (cnt == '0) begin
                    finish    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand shifters, bit counter and sticky decision flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            cnt   <= '0;
            gt_f  <= 1'b0;
            lt_f  <= 1'b0;
            idx_f <= '0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            cnt   <= IDXW'(WIDTH - 1);
            gt_f  <= 1'b0;
            lt_f  <= 1'b0;
            idx_f <= '0;
        end else if (step) begin
            a_sh  <= {a_sh[WIDTH-2:0], 1'b0};
            b_sh  <= {b_sh[WIDTH-2:0], 1'b0};
            cnt   <= cnt - 1'b1;
            gt_f  <= gt_nxt;
            lt_f  <= lt_nxt;
            idx_f <= idx_nxt;
        end
    end

    // Result registers: updated only on the final compare edge, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done          <= 1'b0;
            a_maior_que_b <= 1'b0;
            a_menor_que_b <= 1'b0;
            a_igual_b     <= 1'b0;
            diff_idx      <= '0;
        end else begin
            done <= finish;
            if (finish) begin
                a_maior_que_b <= gt_nxt;
                a_menor_que_b <= lt_nxt;
                a_igual_b     <= ~gt_nxt & ~lt_nxt;
                diff_idx      <= idx_nxt;
            end
        end
    end

endmodule

// File: tb/tb_comparator_nbit_serial.sv
// tb/tb_comparator_nbit_serial.sv - scoreboard bench for comparator_nbit_serial
module tb_comparator_nbit_serial;

    localparam int W  = 8;
    localparam int IW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic          gt;
    logic          lt;
    logic          eq;
    logic [IW-1:0] diff_idx;

    comparator_nbit_serial #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .a             (a),
        .b             (b),
        .busy          (busy),
        .done          (done),
        .a_maior_que_b (gt),
        .a_menor_que_b (lt),
        .a_igual_b     (eq),
        .diff_idx      (diff_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   acc;
        int   dn;
        logic gt;
        logic lt;
        logic eq;
        int   idx;
    } exp_t;

    exp_t q[$];
    int   free_edge = 0;
    logic h_gt = 1'b0;
    logic h_lt = 1'b0;
    logic h_eq = 1'b0;
    int   h_idx = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp_v);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int acc);
        exp_t r;
        r.acc = acc;
        r.dn  = acc + W;
        r.gt  = (x > y);
        r.lt  = (x < y);
        r.eq  = (x == y);
        r.idx = 0;
        for (int i = 0; i < W; i++)
            if (x[i] != y[i]) r.idx = i;
        return r;
    endfunction

    always @(negedge clk) begin
        logic eb;
        logic ed;
        eb = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].dn);
        ed = (q.size() > 0) && (cyc == q[0].dn);
        chk("busy", busy, eb);
        chk("done", done, ed);
        if (ed) begin
            exp_t e;
            e = q.pop_front();
            h_gt  = e.gt;
            h_lt  = e.lt;
            h_eq  = e.eq;
            h_idx = e.idx;
        end
        chk("gt", gt, h_gt);
        chk("lt", lt, h_lt);
        chk("eq", eq, h_eq);
        chk("diff_idx", diff_idx, h_idx);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        a = x;
        b = y;
        if (cyc + 1 >= free_edge) begin
            q.push_back(model(x, y, cyc + 1));
            free_edge = cyc + 1 + W + 1;
        end
        step(1);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_idle();
        while (cyc + 1 < free_edge) step(1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_gt"}, gt, 0);
        chk({nm, "_lt"}, lt, 0);
        chk({nm, "_eq"}, eq, 0);
        chk({nm, "_idx"}, diff_idx, 0);
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        start = 1'b0;
        a = '0;
        b = '0;
        #1 rst_n = 1'b0;
        #1 chk_zero("reset");
        step(2);
        rst_n = 1'b1;
        step(3);

        issue(8'h5A, 8'h5A);
        wait_idle();
        issue(8'h80, 8'h7F);
        wait_idle();
        issue(8'h10, 8'h11);
        step(3);
        issue(8'h00, 8'h00);
        wait_idle();
        issue(8'hFF, 8'h00);
        wait_idle();
        step(W + 2);

        issue(8'h01, 8'h02);
        step(3);
        #2 rst_n = 1'b0;
        q.delete();
        free_edge = 0;
        h_gt = 1'b0;
        h_lt = 1'b0;
        h_eq = 1'b0;
        h_idx = 0;
        #1 chk_zero("abort");
        step(3);
        rst_n = 1'b1;
        step(1);
        issue(8'h33, 8'h31);
        wait_idle();
        step(W + 2);

        for (int i = 0; i < 40; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            if ($urandom_range(0, 3) == 0) y = x;
            if ($urandom_range(0, 4) == 0) y = x ^ W'(1 << $urandom_range(0, W - 1));
            issue(x, y);
            step($urandom_range(0, W + 3));
        end

        for (int i = 0; i < 200 && q.size() > 0; i++) step(1);
        chk("drain", q.size(), 0);
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/comparator_nbit_serial.md
Name: comparator_nbit_serial

Overview:
- Sequential N-bit magnitude comparator that feeds the 1-bit compare stage with one bit pair per clock, MSB first.
- Accepts two WIDTH-bit operands on a start pulse and walks them through a single 1-bit compare slice.
- Latches the first (most significant) differing bit as the decision.
- Reports greater / less / equal plus the index of that bit after a fixed latency.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- IDXW, $clog2(WIDTH), width of diff_idx (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- busy  output  1  high while a comparison is in progress
- done  output  1  one-cycle pulse: result registers just updated
- a_maior_que_b  output  1  A > B (unsigned)
- a_menor_que_b  output  1  A < B (unsigned)
- a_igual_b  output  1  A == B
- diff_idx  output  IDXW  bit index of most significant differing bit; 0 when equal

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately and regardless of clk):
  - State is IDLE; busy=0, done=0.
  - a_maior_que_b=0, a_menor_que_b=0, a_igual_b=0, diff_idx=0 (all-zero means "no result yet").
  - Internal shift registers, bit counter and decision flags are cleared.
- States:
  - IDLE: on edge with start=1, load a and b into shift registers, set cnt=WIDTH-1, clear decision flags (gt_f=0, lt_f=0), set busy=1, go to COMPARE (edge E0). With start=0, stay in IDLE.
  - COMPARE: each edge processes the current MSB pair (a_sh[WIDTH-1], b_sh[WIDTH-1]), then shifts both left by 1 and decrements cnt.
    - If gt_f=0 and lt_f=0 and the bits differ: set gt_f=a bit, lt_f=b bit, and record the index as the current cnt.
    - Once a decision is set, later bits do not change it.
    - When cnt==0 on the edge: go to IDLE and apply the output updates below.
- Output updates on the final COMPARE edge (E_WIDTH):
  - busy<=0, done<=1.
  - a_maior_que_b<=final gt, a_menor_que_b<=final lt, a_igual_b<=~gt&~lt, diff_idx<=recorded index (0 if equal).
  - The final bit (index 0) is included in the decision.
- Latency: start accepted at E0; done is high for exactly the cycle after E_WIDTH, i.e. WIDTH+1 edges after acceptance. The next edge clears done.
- Result outputs hold their value until the next completion. They do not change during a comparison or while start is asserted.
- Exactly one of gt/lt/eq is 1 after any completion. All three are 0 only between reset and the first completion.
- Start while busy=1 is ignored; no queuing, and the operands are not re-captured.
- Start in the cycle where done=1: the FSM is already in IDLE, so the start is accepted on that edge. Back-to-back throughput is one comparison per WIDTH+1 cycles.
- Operand inputs a/b are don't-care except at the accepting edge.
- Reset asserted mid-COMPARE aborts the comparison: outputs return to reset values, no done pulse is produced, and the earlier result is lost.

Test Plan:
- Reset: assert rst_n=0 between clock edges -> busy, done, gt, lt, eq and diff_idx are 0 immediately. Release, idle 3 cycles -> all outputs still 0.
- WIDTH=8: start with a=8'h5A, b=8'h5A -> busy=1 for cycles 1..8, done=1 only in cycle 9, a_igual_b=1, gt=lt=0, diff_idx=0.
- a=8'h80, b=8'h7F -> MSB decides: a_maior_que_b=1, diff_idx=7. Outputs unchanged by the later bits, where b>a.
- a=8'h10, b=8'h11 -> a_menor_que_b=1, diff_idx=0 (last-bit decision). Then pulse start again during busy with a=b=0 -> ignored; result still lt.
- Back-to-back: assert start in the done cycle with a=8'hFF, b=8'h00 -> accepted without an idle gap. Previous result holds until the new done; then gt=1, diff_idx=7.
- Start a=8'h01, b=8'h02, drop rst_n at cycle 4 -> outputs 0 at once and no done pulse. After release, a new start completes normally.
